// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake (FETCH/HOLD/DROP) and IF/ID register.
// Optional macro FETCH_STATS_EN adds saturating fetch/bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PCWrite_i,
  input  logic          IFIDWrite_i,
  input  logic          IFFlush_i,
  input  logic          branch_taken_i,
  input  logic          jump_i,
  input  logic [31:0]   branch_target_i,
  input  logic [31:0]   jump_target_i,
  fetch_stage_if.master imem,
  output logic [31:0]   IFIDPC_o,
  output logic [31:0]   IFIDInstr_o,
  output logic          IFIDValid_o,
  output logic          fetch_busy_o
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]   fetch_count_o,
  output logic [15:0]   bubble_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;

  logic        ack_s, redirect_s, advance_s, deliver_s;
  logic [31:0] target_s, pc_plus4_s, deliver_word_s;

  // ack is only meaningful while a request is actually on the bus
  assign ack_s      = imem.imem_ack & req_q;
  assign redirect_s = IFFlush_i & PCWrite_i & (branch_taken_i | jump_i);
  assign advance_s  = PCWrite_i & IFIDWrite_i & ~IFFlush_i;
  assign target_s   = branch_taken_i ? branch_target_i : jump_target_i;
  assign pc_plus4_s = pc_q + 32'd4;

  // Fetch FSM: next state, PC, request address and hold buffer
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_addr_d     = req_addr_q;
    hold_d         = hold_q;
    deliver_s      = 1'b0;
    deliver_word_s = hold_q;
    case (state_q)
      ST_FETCH: begin
        if (ack_s) begin
          if (redirect_s) begin
            pc_d       = target_s;
            req_addr_d = target_s;
          end else if (advance_s) begin
            deliver_s      = 1'b1;
            deliver_word_s = imem.imem_rdata;
            pc_d           = pc_plus4_s;
            req_addr_d     = pc_plus4_s;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect_s) begin
          pc_d    = target_s;
          state_d = ST_DROP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (advance_s) begin
          deliver_s  = 1'b1;
          pc_d       = pc_plus4_s;
          req_addr_d = pc_plus4_s;
          state_d    = ST_FETCH;
        end else if (redirect_s) begin
          pc_d       = target_s;
          req_addr_d = target_s;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        // the abandoned request keeps its address until acked; pc tracks the newest target
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (ack_s) begin
          req_addr_d = pc_d;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // IF/ID register next value: flush, then stall, then deliver or bubble
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (IFFlush_i) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!IFIDWrite_i) begin
      ifid_valid_d = ifid_valid_q;
    end else if (deliver_s) begin
      ifid_pc_d    = pc_plus4_s;
      ifid_instr_d = deliver_word_s;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  assign req_d  = (state_d != ST_HOLD);
  assign busy_d = (state_d == ST_DROP);

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_q       <= 32'h0000_0000;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_q       <= hold_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_addr_q;
  assign IFIDPC_o       = ifid_pc_q;
  assign IFIDInstr_o    = ifid_instr_q;
  assign IFIDValid_o    = ifid_valid_q;
  assign fetch_busy_o   = busy_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, bubble_cnt_q;
  logic        bubble_s;

  assign bubble_s = IFFlush_i | (IFIDWrite_i & ~deliver_s);

  // Saturating delivery / bubble counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      if (deliver_s && !IFFlush_i && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (bubble_s && (bubble_cnt_q != 16'hFFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the fetch rules.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite, IFIDWrite, IFFlush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] IFIDPC, IFIDInstr;
  logic        IFIDValid, fetch_busy;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count, bubble_count;
`endif

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PCWrite_i       (PCWrite),
    .IFIDWrite_i     (IFIDWrite),
    .IFFlush_i       (IFFlush),
    .branch_taken_i  (branch_taken),
    .jump_i          (jump),
    .branch_target_i (branch_target),
    .jump_target_i   (jump_target),
    .imem            (bus),
    .IFIDPC_o        (IFIDPC),
    .IFIDInstr_o     (IFIDInstr),
    .IFIDValid_o     (IFIDValid),
    .fetch_busy_o    (fetch_busy)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count_o   (fetch_count),
    .bubble_count_o  (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pc, outstanding address, a buffered word, and whether the outstanding request is abandoned
  logic [31:0] m_pc, m_addr, m_hold, m_ifid_pc, m_ifid_instr;
  logic        m_has_hold, m_dropping, m_req, m_ifid_valid;
  logic [31:0] n_pc, n_addr, n_hold, n_ifid_pc, n_ifid_instr;
  logic        n_has_hold, n_dropping, n_ifid_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("imem_req",   32'(bus.imem_req), 32'(m_req));
    chk("imem_addr",  bus.imem_addr, m_addr);
    chk("IFIDPC",     IFIDPC, m_ifid_pc);
    chk("IFIDInstr",  IFIDInstr, m_ifid_instr);
    chk("IFIDValid",  32'(IFIDValid), 32'(m_ifid_valid));
    chk("fetch_busy", 32'(fetch_busy), 32'(m_dropping));
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_addr = RST_PC; m_hold = 32'h0;
    m_has_hold = 1'b0; m_dropping = 1'b0; m_req = 1'b0;
    m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
  endtask

  task automatic model_next();
    logic        ack, redir, adv, got;
    logic [31:0] tgt, word;
    ack   = bus.imem_ack & m_req;
    redir = IFFlush & PCWrite & (branch_taken | jump);
    adv   = PCWrite & IFIDWrite & ~IFFlush;
    tgt   = branch_taken ? branch_target : jump_target;
    got = 1'b0; word = 32'h0;
    n_pc = m_pc; n_addr = m_addr; n_hold = m_hold;
    n_has_hold = m_has_hold; n_dropping = m_dropping;
    if (m_has_hold) begin
      if (adv) begin
        got = 1'b1; word = m_hold; n_has_hold = 1'b0;
        n_pc = m_pc + 32'd4; n_addr = n_pc;
      end else if (redir) begin
        n_has_hold = 1'b0; n_pc = tgt; n_addr = tgt;
      end
    end else if (m_dropping) begin
      if (redir) n_pc = tgt;
      if (ack) begin
        n_addr = n_pc; n_dropping = 1'b0;
      end
    end else if (ack) begin
      if (redir) begin
        n_pc = tgt; n_addr = tgt;
      end else if (adv) begin
        got = 1'b1; word = bus.imem_rdata;
        n_pc = m_pc + 32'd4; n_addr = n_pc;
      end else begin
        n_hold = bus.imem_rdata; n_has_hold = 1'b1;
      end
    end else if (redir) begin
      n_pc = tgt; n_dropping = 1'b1;
    end
    n_ifid_pc = m_ifid_pc; n_ifid_instr = m_ifid_instr; n_ifid_valid = m_ifid_valid;
    if (IFFlush) begin
      n_ifid_instr = NOP; n_ifid_valid = 1'b0;
    end else if (IFIDWrite) begin
      if (got) begin
        n_ifid_pc = m_pc + 32'd4; n_ifid_instr = word; n_ifid_valid = 1'b1;
      end else begin
        n_ifid_instr = NOP; n_ifid_valid = 1'b0;
      end
    end
  endtask

  // Inputs are set by the caller at the falling edge before calling tick
  task automatic tick();
    model_next();
    @(posedge clk);
    m_pc = n_pc; m_addr = n_addr; m_hold = n_hold;
    m_has_hold = n_has_hold; m_dropping = n_dropping; m_req = ~n_has_hold;
    m_ifid_pc = n_ifid_pc; m_ifid_instr = n_ifid_instr; m_ifid_valid = n_ifid_valid;
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_ctl(input logic pcw, input logic ifw, input logic fl,
                         input logic bt, input logic jp, input logic ack, input logic [31:0] rd);
    PCWrite = pcw; IFIDWrite = ifw; IFFlush = fl; branch_taken = bt; jump = jp;
    bus.imem_ack = ack; bus.imem_rdata = rd;
  endtask

  // Called at a falling edge: asserts reset mid-cycle, checks immediately, releases at a later falling edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_req_now", 32'(bus.imem_req), 32'h0);
    chk("rst_valid_now", 32'(IFIDValid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0000);
    branch_target = 32'h0; jump_target = 32'h0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("reset_addr", bus.imem_addr, 32'h0);
    chk("reset_instr", IFIDInstr, NOP);
    rst_n = 1'b1;

    // Back-to-back zero-wait fetches from reset
    bus.imem_rdata = 32'hA000_0000; tick();
    chk("t1_req", 32'(bus.imem_req), 32'h1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    bus.imem_rdata = 32'hA000_0001; tick();
    chk("t1_addr4", bus.imem_addr, 32'h4);
    chk("t1_pc4", IFIDPC, 32'h4);
    chk("t1_instr", IFIDInstr, 32'hA000_0001);
    bus.imem_rdata = 32'hA000_0002; tick();
    chk("t1_addr8", bus.imem_addr, 32'h8);
    chk("t1_pc8", IFIDPC, 32'h8);
    bus.imem_rdata = 32'hA000_0003; tick();
    chk("t1_pc12", IFIDPC, 32'hC);
    tick();
    chk("t2_addr10", bus.imem_addr, 32'h10);

    // Three wait cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_0000);
      tick();
      chk("t2_addr_stable", bus.imem_addr, 32'h10);
      chk("t2_bubble", 32'(IFIDValid), 32'h0);
    end
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
    tick();
    chk("t2_pc14", IFIDPC, 32'h14);
    chk("t2_instr", IFIDInstr, 32'hCAFE_0001);

    // Ack during a full stall is buffered
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0002);
    tick();
    chk("t3_req_low", 32'(bus.imem_req), 32'h0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    tick();
    chk("t3_instr_held", IFIDInstr, 32'hCAFE_0001);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t3_instr_buf", IFIDInstr, 32'hBEEF_0002);
    chk("t3_pc18", IFIDPC, 32'h18);
    chk("t3_addr18", bus.imem_addr, 32'h18);

    // Redirect while the request at 0x40 is unacked
    for (int i = 0; i < 20 && m_addr != 32'h40; i++) begin
      set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom());
      tick();
    end
    chk("t4_reach40", bus.imem_addr, 32'h40);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    branch_target = 32'h200; jump_target = 32'h300;
    tick();
    chk("t4_busy", 32'(fetch_busy), 32'h1);
    chk("t4_flush_valid", 32'(IFIDValid), 32'h0);
    chk("t4_addr_kept", bus.imem_addr, 32'h40);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0003);
    tick();
    chk("t4_not_busy", 32'(fetch_busy), 32'h0);
    chk("t4_addr200", bus.imem_addr, 32'h200);
    chk("t4_discard", 32'(IFIDValid), 32'h0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_0004);
    tick();
    chk("t4_pc204", IFIDPC, 32'h204);

    // Branch beats jump
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    branch_target = 32'h100; jump_target = 32'h300;
    tick();
    chk("t5_addr100", bus.imem_addr, 32'h100);

    // PC wrap at the top of the address space
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    jump_target = 32'hFFFF_FFFC;
    tick();
    chk("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_0005);
    tick();
    chk("t6_pc_wrap", IFIDPC, 32'h0);
    chk("t6_addr_wrap", bus.imem_addr, 32'h0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    async_reset();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      PCWrite      = ($urandom_range(99) < 85);
      IFIDWrite    = ($urandom_range(99) < 85);
      IFFlush      = ($urandom_range(99) < 15);
      branch_taken = ($urandom_range(99) < 50);
      jump         = ($urandom_range(99) < 40);
      r = $urandom(); branch_target = r & 32'hFFFF_FFFC;
      r = $urandom(); jump_target   = r & 32'hFFFF_FFFC;
      bus.imem_ack   = ($urandom_range(99) < 55);
      bus.imem_rdata = $urandom();
      if ($urandom_range(399) == 0) begin
        async_reset();
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
